simple_merger: RTL

- 4-to-1 merger with round-robin arbitration; the collecting end of the 4-way address-routed split.
- Four independent valid/ready source channels feed one registered output channel.
- Output carries the payload and a 2-bit tag for the source index.
- Sits downstream of the 4-output router, recombining its traffic onto one stream.

---
 rtl/simple_merger_pkg.sv | 10 +
 rtl/simple_merger_if.sv | 30 +++
 rtl/rr_arbiter4.sv | 29 ++
 rtl/simple_merger.sv | 95 +++++++++
 4 files changed

// File: rtl/simple_merger_pkg.sv
// Shared types and sizes for the 4-to-1 round-robin merger.
package simple_merger_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = 2;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [NUM_PORTS-1:0]  port_mask_t;

endpackage

// File: rtl/simple_merger_if.sv
// Source and sink handshake bundle for simple_merger.
// The master side drives sources and the sink ready; the slave side is the merger.
interface simple_merger_if
    import simple_merger_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] din1;
    logic [DATA_WIDTH-1:0] din2;
    logic [DATA_WIDTH-1:0] din3;
    port_mask_t            din_valid;
    port_mask_t            din_ready;
    logic [DATA_WIDTH-1:0] dout;
    port_idx_t             dout_src;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output din0, din1, din2, din3, din_valid, dout_ready,
        input  din_ready, dout, dout_src, dout_valid
    );

    modport slave (
        input  din0, din1, din2, din3, din_valid, dout_ready,
        output din_ready, dout, dout_src, dout_valid
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr.
module rr_arbiter4
    import simple_merger_pkg::*;
(
    input  port_mask_t req,
    input  port_idx_t  ptr,
    output port_mask_t grant,
    output port_idx_t  grant_idx,
    output logic       any_grant
);

    always_comb begin
        port_idx_t cand;
        grant     = '0;
        grant_idx = ptr;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            // k == NUM_PORTS wraps to an offset of zero, so ptr itself is searched last
            cand = ptr + port_idx_t'(k);
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_merger.sv
// 4-to-1 round-robin merger with a registered output stage.
// Optional per-source bursting is enabled by defining MERGER_BURST_EN.
module simple_merger
    import simple_merger_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef MERGER_BURST_EN
    ,
    parameter int MAX_BURST  = 4
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    simple_merger_if.slave  bus
);

    logic [DATA_WIDTH-1:0] dout_q;
    port_idx_t             dout_src_q;
    logic                  dout_valid_q;
    port_idx_t             ptr;
    port_idx_t             arb_ptr;
    port_mask_t            grant;
    port_idx_t             grant_idx;
    logic                  any_grant;
    logic                  load_en;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    assign load_en = !dout_valid_q || bus.dout_ready;
    // Gate with resetn so sources never see a grant while the block is held in reset
    assign xfer    = load_en && any_grant && resetn;

    rr_arbiter4 u_arb (
        .req       (bus.din_valid),
        .ptr       (arb_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_data = bus.din0;
        case (grant_idx)
            2'd0:    sel_data = bus.din0;
            2'd1:    sel_data = bus.din1;
            2'd2:    sel_data = bus.din2;
            default: sel_data = bus.din3;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q       <= '0;
            dout_src_q   <= '0;
            dout_valid_q <= 1'b0;
            ptr          <= 2'd3;
        end else if (load_en) begin
            if (any_grant) begin
                dout_q       <= sel_data;
                dout_src_q   <= grant_idx;
                dout_valid_q <= 1'b1;
                ptr          <= grant_idx;
            end else begin
                dout_valid_q <= 1'b0;
            end
        end
    end

`ifdef MERGER_BURST_EN
    logic [7:0] burst_cnt;
    logic       hold_prio;

    // Starting the search one below ptr puts the current burst owner first
    assign hold_prio = (burst_cnt != 8'd0) && (burst_cnt < 8'(MAX_BURST)) && bus.din_valid[ptr];
    assign arb_ptr   = hold_prio ? ptr - 2'd1 : ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            burst_cnt <= '0;
        end else if (xfer) begin
            burst_cnt <= (hold_prio && grant_idx == ptr) ? burst_cnt + 8'd1 : 8'd1;
        end else if (!bus.din_valid[ptr]) begin
            burst_cnt <= '0;
        end
    end
`else
    assign arb_ptr = ptr;
`endif

    assign bus.din_ready  = xfer ? grant : '0;
    assign bus.dout       = dout_q;
    assign bus.dout_src   = dout_src_q;
    assign bus.dout_valid = dout_valid_q;

endmodule
